// File: rtl/rob_marker_tracker.sv
// Phase-marker tracker: decodes slti x0,x0,k markers on ROB enq/commit slot 0,
// queues timestamped records and tracks committed phase. Option: MARKER_TAINT_PEAK_EN.
//
//  state | meaning
//  IDLE  | no phase open
//  VCTM  | victim phase      (k=0 start, k=1 end)
//  DELAY | delay phase       (k=2/3)
//  TEXE  | transient exec    (k=4/5)
//  LEAK  | leak phase        (k=6/7)
//  INIT  | init phase        (k=8/9)
//  BIM   | bimodal phase     (k=10/11)
//  TRAIN | training phase    (k=12/13)
module rob_marker_tracker #(
   parameter int DEPTH   = 8,
   parameter int TAINT_W = 32
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               enq_valid,
   input  logic [31:0]        enq_inst,
   input  logic               commit_valid,
   input  logic [31:0]        commit_inst,
   input  logic [TAINT_W-1:0] taint_base,
   input  logic [TAINT_W-1:0] taint_vnt,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic               evt_commit,
   output logic [3:0]         evt_idx,
   output logic [63:0]        evt_time,
   output logic [TAINT_W-1:0] evt_taint_b,
   output logic [TAINT_W-1:0] evt_taint_v,
   output logic [2:0]         phase,
   output logic               phase_err,
   output logic [15:0]        drop_cnt,
   output logic [TAINT_W-1:0] peak_taint
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = 1 + 4 + 64 + 2 * TAINT_W;

   typedef enum logic [2:0] {IDLE, VCTM, DELAY, TEXE, LEAK, INIT, BIM, TRAIN} phase_t;

   logic [63:0]   cyc;
   logic [RW-1:0] mem [DEPTH];
   logic [RW-1:0] head;
   logic [AW-1:0] rptr, wptr, com_slot;
   logic [AW:0]   count;
   logic [AW+1:0] free;
   logic          enq_hit, com_hit, push_enq, push_com, pop;
   logic [1:0]    n_drop;
   logic [16:0]   drop_sum;
   phase_t        phase_q, phase_d, tgt;
   logic          err_d;

   assign enq_hit = enq_valid && (enq_inst[19:0] == 20'h02013) && (enq_inst[31:20] <= 12'd13);
   assign com_hit = commit_valid && (commit_inst[19:0] == 20'h02013) && (commit_inst[31:20] <= 12'd13);

   assign evt_valid = (count != '0);
   assign pop       = evt_valid && evt_ready;
   assign free      = (AW+2)'(DEPTH) - {1'b0, count} + {{(AW+1){1'b0}}, pop};

   // The enqueue record always wins the last free slot.
   assign push_enq = enq_hit && (free != '0);
   assign push_com = com_hit && (enq_hit ? (free >= (AW+2)'(2)) : (free != '0));
   assign n_drop   = {1'b0, enq_hit && !push_enq} + {1'b0, com_hit && !push_com};
   assign com_slot = push_enq ? wptr + AW'(1) : wptr;
   assign drop_sum = {1'b0, drop_cnt} + {15'd0, n_drop};

   always_ff @(posedge clock) begin
      if (push_enq) mem[wptr]     <= {1'b0, enq_inst[23:20], cyc, taint_base, taint_vnt};
      if (push_com) mem[com_slot] <= {1'b1, commit_inst[23:20], cyc, taint_base, taint_vnt};
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cyc       <= '0;
         rptr      <= '0;
         wptr      <= '0;
         count     <= '0;
         drop_cnt  <= '0;
         phase_q   <= IDLE;
         phase_err <= 1'b0;
      end else begin
         cyc       <= cyc + 64'd1;
         rptr      <= rptr + AW'(pop);
         wptr      <= wptr + AW'(push_enq) + AW'(push_com);
         count     <= count + (AW+1)'(push_enq) + (AW+1)'(push_com) - (AW+1)'(pop);
         drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
         phase_q   <= phase_d;
         phase_err <= err_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      err_d   = phase_err;
      tgt     = phase_t'(commit_inst[23:21] + 3'd1);
      if (com_hit) begin
         if (!commit_inst[20]) begin
            phase_d = tgt;
            if (phase_q != IDLE) err_d = 1'b1;
         end else if (phase_q == tgt) begin
            phase_d = IDLE;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   // Head fields are masked so an empty FIFO presents all-zero outputs.
   assign head        = evt_valid ? mem[rptr] : '0;
   assign evt_commit  = head[RW-1];
   assign evt_idx     = head[RW-2 -: 4];
   assign evt_time    = head[2*TAINT_W +: 64];
   assign evt_taint_b = head[TAINT_W +: TAINT_W];
   assign evt_taint_v = head[0 +: TAINT_W];
   assign phase       = phase_q;

`ifdef MARKER_TAINT_PEAK_EN
   logic [TAINT_W-1:0] diff;
   assign diff = (taint_base >= taint_vnt) ? taint_base - taint_vnt : taint_vnt - taint_base;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         peak_taint <= '0;
      end else if (phase_q == IDLE) begin
         if (phase_d != IDLE) peak_taint <= '0;
      end else if (diff > peak_taint) begin
         peak_taint <= diff;
      end
   end
`else
   assign peak_taint = '0;
`endif
endmodule

// File: tb/tb_rob_marker_tracker.sv
// Directed bench for rob_marker_tracker: scoreboard of expected records, phase and drop checks.
module tb_rob_marker_tracker;
   localparam int TW = 32;

   logic          clock = 1'b0;
   logic          reset_n = 1'b0;
   logic          enq_valid = 1'b0, commit_valid = 1'b0, evt_ready = 1'b0;
   logic [31:0]   enq_inst = '0, commit_inst = '0;
   logic [TW-1:0] taint_base = '0, taint_vnt = '0;
   logic          evt_valid, evt_commit, phase_err;
   logic [3:0]    evt_idx;
   logic [63:0]   evt_time;
   logic [TW-1:0] evt_taint_b, evt_taint_v, peak_taint;
   logic [2:0]    phase;
   logic [15:0]   drop_cnt;

   rob_marker_tracker #(.DEPTH(8), .TAINT_W(TW)) dut (
      .clock(clock), .reset_n(reset_n),
      .enq_valid(enq_valid), .enq_inst(enq_inst),
      .commit_valid(commit_valid), .commit_inst(commit_inst),
      .taint_base(taint_base), .taint_vnt(taint_vnt),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_commit(evt_commit), .evt_idx(evt_idx), .evt_time(evt_time),
      .evt_taint_b(evt_taint_b), .evt_taint_v(evt_taint_v),
      .phase(phase), .phase_err(phase_err), .drop_cnt(drop_cnt), .peak_taint(peak_taint)
   );

   always #5 clock = ~clock;

   logic [63:0] tb_cyc;
   always @(posedge clock or negedge reset_n)
      if (!reset_n) tb_cyc <= '0;
      else          tb_cyc <= tb_cyc + 64'd1;

   typedef struct {
      logic          c;
      logic [3:0]    k;
      logic [63:0]   t;
      logic [TW-1:0] b;
      logic [TW-1:0] v;
   } rec_t;

   rec_t sb[$];
   int   total = 0, bad = 0, mcount = 0, exp_drop = 0;

`ifdef MARKER_TAINT_PEAK_EN
   localparam logic [TW-1:0] PEAK_EXP = 8;
`else
   localparam logic [TW-1:0] PEAK_EXP = 0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   function automatic logic is_mark(input logic [31:0] i);
      return (i[19:0] == 20'h02013) && (i[31:20] <= 12'd13);
   endfunction

   task automatic rnd_taint;
      taint_base = $urandom;
      taint_vnt  = $urandom;
   endtask

   // Drive one cycle of markers; expected records go to the scoreboard if the model has room.
   task automatic drive(input logic ev, input logic [31:0] ei, input logic cv, input logic [31:0] ci);
      int   free;
      logic pop_now;
      rec_t r;
      enq_valid = ev; enq_inst = ei; commit_valid = cv; commit_inst = ci;
      pop_now = evt_ready && (mcount > 0);
      free = 8 - mcount + (pop_now ? 1 : 0);
      if (pop_now) begin
         r = sb.pop_front();
         chk("drvpop_idx", evt_idx, r.k);
         chk("drvpop_time", evt_time, r.t);
         mcount--;
      end
      if (ev && is_mark(ei)) begin
         if (free > 0) begin
            r = '{1'b0, ei[23:20], tb_cyc, taint_base, taint_vnt};
            sb.push_back(r); free--; mcount++;
         end else exp_drop++;
      end
      if (cv && is_mark(ci)) begin
         if (free > 0) begin
            r = '{1'b1, ci[23:20], tb_cyc, taint_base, taint_vnt};
            sb.push_back(r); free--; mcount++;
         end else exp_drop++;
      end
      tick;
      enq_valid = 1'b0; commit_valid = 1'b0;
   endtask

   task automatic pop_check(input string tag);
      rec_t r;
      if (sb.size() == 0) begin
         total++; bad++;
         $error("FAIL %s_sb observed=empty expected=record", tag);
         return;
      end
      r = sb.pop_front();
      chk({tag, "_valid"},  evt_valid,   1);
      chk({tag, "_commit"}, evt_commit,  r.c);
      chk({tag, "_idx"},    evt_idx,     r.k);
      chk({tag, "_time"},   evt_time,    r.t);
      chk({tag, "_tb"},     evt_taint_b, r.b);
      chk({tag, "_tv"},     evt_taint_v, r.v);
      evt_ready = 1'b1;
      tick;
      evt_ready = 1'b0;
      mcount--;
   endtask

   initial begin
      // reset
      tick; tick;
      chk("rst_valid", evt_valid, 0);
      chk("rst_phase", phase, 0);
      chk("rst_err", phase_err, 0);
      chk("rst_drop", drop_cnt, 0);
      chk("rst_time", evt_time, 0);
      chk("rst_peak", peak_taint, 0);
      reset_n = 1'b1;

      // 1: single commit marker at counter 20
      for (int i = 0; i < 100 && tb_cyc != 64'd20; i++) tick;
      chk("t1_cyc_reach", tb_cyc, 20);
      evt_ready = 1'b1;
      rnd_taint();
      drive(0, 0, 1, 32'h00002013);
      chk("t1_phase", phase, 1);
      pop_check("t1_rec");
      chk("t1_valid_after", evt_valid, 0);

      // 2: pairing
      rnd_taint(); drive(0, 0, 1, 32'h00102013);
      chk("t2_vctm_end", phase, 0);
      rnd_taint(); drive(0, 0, 1, 32'h00202013);
      chk("t2_delay", phase, 2);
      rnd_taint(); drive(0, 0, 1, 32'h00302013);
      chk("t2_idle", phase, 0);
      chk("t2_err0", phase_err, 0);
      rnd_taint(); drive(0, 0, 1, 32'h00102013);
      chk("t2_err1", phase_err, 1);
      chk("t2_idle2", phase, 0);
      for (int i = 0; i < 4; i++) pop_check("t2_rec");

      // 3: simultaneous enq + commit
      rnd_taint(); drive(1, 32'h00802013, 1, 32'h00902013);
      pop_check("t3_enq");
      pop_check("t3_com");
      chk("t3_empty", evt_valid, 0);

      // 4: overflow
      for (int i = 0; i < 9; i++) begin
         rnd_taint();
         drive(1, {8'h00, 4'(i), 20'h02013}, 0, 0);
      end
      rnd_taint(); drive(1, 32'h00a02013, 1, 32'h00b02013);
      chk("t4_drop3", drop_cnt, 3);
      chk("t4_drop_model", drop_cnt, exp_drop);
      chk("t4_full_valid", evt_valid, 1);
      chk("t4_phase", phase, 0);
      evt_ready = 1'b1;
      rnd_taint(); drive(1, 32'h00502013, 0, 0);
      evt_ready = 1'b0;
      chk("t4_pop_frees_slot", drop_cnt, 3);
      for (int i = 0; i < 8; i++) pop_check("t4_drain");
      chk("t4_empty", evt_valid, 0);
      for (int i = 0; i < 7; i++) begin
         rnd_taint();
         drive(1, {8'h00, 4'(i + 3), 20'h02013}, 0, 0);
      end
      rnd_taint(); drive(1, 32'h00202013, 1, 32'h00302013);
      chk("t4_one_slot_drop", drop_cnt, 4);
      chk("t4_drop_model2", drop_cnt, exp_drop);
      for (int i = 0; i < 8; i++) pop_check("t4_drain2");
      chk("t4_empty2", evt_valid, 0);

      // 5: non-markers leave phase and FIFO alone
      rnd_taint(); drive(0, 0, 1, 32'h00c02013);
      chk("t5_train", phase, 7);
      pop_check("t5_start");
      rnd_taint(); drive(1, 32'h00e02013, 1, 32'h00e02013);
      rnd_taint(); drive(1, 32'h00002093, 1, 32'h00002093);
      tick;
      chk("t5_no_rec", evt_valid, 0);
      chk("t5_phase_hold", phase, 7);
      rnd_taint(); drive(0, 0, 1, 32'h00d02013);
      chk("t5_idle", phase, 0);
      pop_check("t5_end");

      // 6: taint peak over a TRAIN phase
      taint_base = 0; taint_vnt = 0;
      drive(0, 0, 1, 32'h00c02013);
      chk("t6_peak_clear", peak_taint, 0);
      taint_base = 5; taint_vnt = 2; tick;
      taint_base = 9; taint_vnt = 1; tick;
      taint_base = 3; taint_vnt = 3; tick;
      taint_base = 0; taint_vnt = 0;
      drive(0, 0, 1, 32'h00d02013);
      chk("t6_idle", phase, 0);
      chk("t6_peak", peak_taint, PEAK_EXP);
      taint_base = 100; taint_vnt = 0; tick; tick;
      chk("t6_peak_hold", peak_taint, PEAK_EXP);
      pop_check("t6_start");
      pop_check("t6_end");

      // reset mid-operation, then START while a phase is open
      for (int i = 0; i < 3; i++) begin
         rnd_taint();
         drive(1, 32'h00402013, 0, 0);
      end
      evt_ready = 1'b1;
      reset_n = 1'b0;
      #1;
      chk("mr_valid", evt_valid, 0);
      chk("mr_drop", drop_cnt, 0);
      chk("mr_err", phase_err, 0);
      chk("mr_time", evt_time, 0);
      tick;
      evt_ready = 1'b0;
      sb.delete(); mcount = 0; exp_drop = 0;
      reset_n = 1'b1;
      tick;
      chk("mr_still_empty", evt_valid, 0);
      rnd_taint(); drive(0, 0, 1, 32'h00402013);
      chk("mr_texe", phase, 3);
      chk("mr_err0", phase_err, 0);
      rnd_taint(); drive(0, 0, 1, 32'h00602013);
      chk("mr_leak", phase, 4);
      chk("mr_err_restart", phase_err, 1);
      pop_check("mr_rec");
      pop_check("mr_rec");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
